branch_hazard_ctrl: RTL

- Hazard/stall controller for branches resolved in ID using MEM/WB forwarded operands.
- Detects branch source-register dependences that forwarding cannot cover: a producer still in EX, or a load in EX/MEM.
- Sequences multi-cycle stalls through a small FSM with a down-counter.
- Drives PC/IF-ID hold, ID-EX bubble insertion and the IF-ID flush on a taken branch.

---
 rtl/branch_hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: stall/flush control for branches resolved in ID.
// A branch whose source is produced by an instruction still in EX, or by a
// load in EX/MEM, cannot use forwarding and must stall. A 1-cycle stall is
// handled combinationally in IDLE. A load in EX is handled by one extra
// cycle in STALL.
// Optional feature: define BRANCH_STALL_CNT_EN to add the saturating
// stall_cycles output, which counts the cycles where PC_stall is high.
module branch_hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              isBranch_ID,
  input  logic              branch_taken_ID,
  input  logic [ADDR_W-1:0] RegRdaddr1_ID,
  input  logic [ADDR_W-1:0] RegRdaddr2_ID,
  input  logic              RegWrite_EX,
  input  logic              MemRead_EX,
  input  logic [ADDR_W-1:0] RegWtaddr_EX,
  input  logic              RegWrite_MEM,
  input  logic              MemRead_MEM,
  input  logic [ADDR_W-1:0] RegWtaddr_MEM,
  input  logic              flush_ext,
  output logic              PC_stall,
  output logic              IFID_stall,
  output logic              IDEX_flush,
  output logic              IFID_flush,
  output logic              busy
`ifdef BRANCH_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_e;

  state_e state_q, state_d;
  logic   cnt_q, cnt_d;
  logic   dep_ex, dep_mem_ld, hazard, stall, hold;
  logic [1:0] need;

  // Dependence detection; register 0 never creates a hazard.
  always_comb begin
    dep_ex     = isBranch_ID && RegWrite_EX && (RegWtaddr_EX != '0) &&
                 ((RegWtaddr_EX == RegRdaddr1_ID) || (RegWtaddr_EX == RegRdaddr2_ID));
    dep_mem_ld = isBranch_ID && RegWrite_MEM && MemRead_MEM && (RegWtaddr_MEM != '0) &&
                 ((RegWtaddr_MEM == RegRdaddr1_ID) || (RegWtaddr_MEM == RegRdaddr2_ID));
    if (dep_ex && MemRead_EX)      need = 2'd2;
    else if (dep_ex || dep_mem_ld) need = 2'd1;
    else                           need = 2'd0;
    hazard = (need != 2'd0);
  end

  // Output decode; outputs are held at 0 while reset is asserted.
  always_comb begin
    stall      = rst_n && ((state_q == STALL) || hazard);
    hold       = stall && !flush_ext;
    PC_stall   = hold;
    IFID_stall = hold;
    IDEX_flush = hold;
    IFID_flush = rst_n && (flush_ext || (isBranch_ID && branch_taken_ID && !stall));
    busy       = (state_q == STALL);
  end

  // Next state. The detect cycle in IDLE is the first stall cycle, so a
  // load in EX spends exactly one more cycle in STALL (cnt loads 0). cnt=1
  // would extend STALL by one more cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_ext) begin
      state_d = IDLE;
      cnt_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (need == 2'd2) begin
            state_d = STALL;
            cnt_d   = 1'b0;
          end
        end
        STALL: begin
          if (cnt_q) cnt_d = 1'b0;
          else       state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BRANCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q;

  // Saturating count of cycles where the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cycles_q <= '0;
    else if (hold && (stall_cycles_q != '1))    stall_cycles_q <= stall_cycles_q + 1'b1;
  end

  assign stall_cycles = stall_cycles_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
